// File: rtl/rob_commit_pkg.sv
// Shared sizing constants for the rob_commit reorder buffer and its pointer pair.
package rob_commit_pkg;
  localparam int RRF_SEL = 6;
  localparam int RRF_NUM = 2 ** RRF_SEL;
  localparam int REG_SEL = 5;
  localparam int PTR_W   = RRF_SEL + 1;
endpackage

// File: rtl/rob_ptr.sv
// Head/tail pointer pair with wrap bit; derives occupancy, full and empty.
// Optional ROB_FLUSH_EN adds a flush input that collapses tail onto the new head.
module rob_ptr
  import rob_commit_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             head_inc,
  input  logic             tail_inc,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty
);
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W-1:0] head_next, tail_next;

  // The extra MSB acts as the wrap bit, so plain modular arithmetic yields count.
  always_comb begin
    head_next = head_reg + PTR_W'(head_inc);
    tail_next = tail_reg + PTR_W'(tail_inc);
`ifdef ROB_FLUSH_EN
    if (flush) tail_next = head_next;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign count = tail_reg - head_reg;
  assign full  = (count == PTR_W'(RRF_NUM));
  assign empty = (count == '0);
endmodule

// File: rtl/rob_commit.sv
// In-order reorder-buffer commit engine driving the ARF/rename commit interface.
// Optional macro ROB_FLUSH_EN adds flush_i (clear all entries, tail = head).
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_n_i,
`ifdef ROB_FLUSH_EN
  input  logic               flush_i,
`endif
  input  logic               dp_alloc_i,
  input  logic               dp_dst_en_i,
  input  logic [REG_SEL-1:0] dp_dst_num_i,
  output logic [RRF_SEL-1:0] dp_rrftag_o,
  output logic               rob_full_o,
  output logic [RRF_SEL:0]   rob_count_o,
  input  logic               ex_done_i,
  input  logic [RRF_SEL-1:0] ex_rrftag_i,
  output logic               commit_valid_o,
  output logic               completed_we_o,
  output logic [REG_SEL-1:0] completed_dst_num_o,
  output logic [RRF_SEL-1:0] completed_dst_rrftag_o
);
  logic [PTR_W-1:0]   head, tail, count;
  logic               full, empty;
  logic [RRF_SEL-1:0] head_idx, tail_idx;
  logic               alloc_fire, done_fire, commit_fire, flush;
  logic [RRF_NUM-1:0] valid_reg, finished_reg, dst_en_reg;
  logic [REG_SEL-1:0] dst_num_reg [RRF_NUM];

`ifdef ROB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign head_idx = head[RRF_SEL-1:0];
  assign tail_idx = tail[RRF_SEL-1:0];

  // Full is judged on the pre-commit count, so a same-cycle retire never frees a slot early.
  assign alloc_fire  = dp_alloc_i && !full && !flush;
  assign done_fire   = ex_done_i && !flush && valid_reg[ex_rrftag_i]
                       && !(alloc_fire && (ex_rrftag_i == tail_idx));
  assign commit_fire = !empty && valid_reg[head_idx] && finished_reg[head_idx];

  rob_ptr u_ptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .head_inc  (commit_fire),
    .tail_inc  (alloc_fire),
`ifdef ROB_FLUSH_EN
    .flush     (flush),
`endif
    .head      (head),
    .tail      (tail),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  generate
    for (genvar gi = 0; gi < RRF_NUM; gi++) begin : g_entry
      logic               valid_q, finished_q, dst_en_q;
      logic [REG_SEL-1:0] dst_num_q;

      // Allocation and commit never target the same slot: that needs full or empty.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          valid_q    <= 1'b0;
          finished_q <= 1'b0;
          dst_en_q   <= 1'b0;
          dst_num_q  <= '0;
        end else if (flush) begin
          valid_q    <= 1'b0;
          finished_q <= 1'b0;
        end else if (alloc_fire && (tail_idx == RRF_SEL'(gi))) begin
          valid_q    <= 1'b1;
          finished_q <= 1'b0;
          dst_en_q   <= dp_dst_en_i;
          dst_num_q  <= dp_dst_num_i;
        end else if (commit_fire && (head_idx == RRF_SEL'(gi))) begin
          valid_q    <= 1'b0;
          finished_q <= 1'b0;
        end else if (done_fire && (ex_rrftag_i == RRF_SEL'(gi))) begin
          finished_q <= 1'b1;
        end
      end

      assign valid_reg[gi]    = valid_q;
      assign finished_reg[gi] = finished_q;
      assign dst_en_reg[gi]   = dst_en_q;
      assign dst_num_reg[gi]  = dst_num_q;
    end
  endgenerate

  assign dp_rrftag_o            = tail_idx;
  assign rob_full_o             = full;
  assign rob_count_o            = count;
  assign commit_valid_o         = commit_fire;
  assign completed_dst_rrftag_o = head_idx;
  assign completed_dst_num_o    = dst_num_reg[head_idx];
  assign completed_we_o         = commit_fire && dst_en_reg[head_idx]
                                  && (dst_num_reg[head_idx] != '0);
endmodule

// File: tb/tb_rob_commit.sv
// Randomized + directed self-checking bench for rob_commit against a program-order queue model.
module tb_rob_commit;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush;
  logic       dp_alloc, dp_dst_en, ex_done;
  logic [4:0] dp_dst_num;
  logic [5:0] dp_rrftag, ex_rrftag, completed_dst_rrftag;
  logic       rob_full, commit_valid, completed_we;
  logic [6:0] rob_count;
  logic [4:0] completed_dst_num;

  rob_commit dut (
    .clk_i                  (clk),
    .reset_n_i              (reset_n),
`ifdef ROB_FLUSH_EN
    .flush_i                (flush),
`endif
    .dp_alloc_i             (dp_alloc),
    .dp_dst_en_i            (dp_dst_en),
    .dp_dst_num_i           (dp_dst_num),
    .dp_rrftag_o            (dp_rrftag),
    .rob_full_o             (rob_full),
    .rob_count_o            (rob_count),
    .ex_done_i              (ex_done),
    .ex_rrftag_i            (ex_rrftag),
    .commit_valid_o         (commit_valid),
    .completed_we_o         (completed_we),
    .completed_dst_num_o    (completed_dst_num),
    .completed_dst_rrftag_o (completed_dst_rrftag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    bit en;
    int num;
    bit fin;
  } ent_t;

  ent_t q[$];
  int   head_p;
  int   tail_p;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance the model at the edge.
  task automatic step(input bit a, input bit en, input int num, input bit d, input int dtag,
                      input bit fl);
    int size;
    bit full_e, cv, we, fire_a;
    @(negedge clk);
    dp_alloc = a; dp_dst_en = en; dp_dst_num = 5'(num);
    ex_done = d; ex_rrftag = 6'(dtag); flush = fl;
    #1;
    size   = q.size();
    full_e = (size == 64);
    cv     = (size > 0) && q[0].fin;
    we     = cv && q[0].en && (q[0].num != 0);
    $display("cyc a=%0b en=%0b num=%0d d=%0b dtag=%0d fl=%0b count=%0d cv=%0b we=%0b",
             a, en, num, d, dtag, fl, rob_count, commit_valid, completed_we);
    check("count", 32'(rob_count), 32'(size));
    check("full", 32'(rob_full), 32'(full_e));
    check("dp_rrftag", 32'(dp_rrftag), 32'(tail_p % 64));
    check("commit_valid", 32'(commit_valid), 32'(cv));
    check("completed_we", 32'(completed_we), 32'(we));
    check("commit_tag", 32'(completed_dst_rrftag), 32'(head_p % 64));
    if (cv) check("commit_num", 32'(completed_dst_num), 32'(q[0].num));
    @(posedge clk);
    fire_a = a && !full_e && !fl;
    if (d && !fl)
      foreach (q[i]) if (q[i].tag == dtag) q[i].fin = 1'b1;
    if (cv) begin
      void'(q.pop_front());
      head_p = (head_p + 1) % 128;
    end
    if (fl) begin
      q.delete();
      tail_p = head_p;
    end else if (fire_a) begin
      q.push_back('{tag: tail_p % 64, en: en, num: num, fin: 1'b0});
      tail_p = (tail_p + 1) % 128;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() > 0; i++) step(0, 0, 0, 1, q[0].tag, 0);
    check("drain_done", 32'(q.size()), 32'd0);
  endtask

  // Asserts reset between edges and expects every output to clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    dp_alloc = 0; ex_done = 0; flush = 0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_count", 32'(rob_count), 32'd0);
    check("rst_full", 32'(rob_full), 32'd0);
    check("rst_tag", 32'(dp_rrftag), 32'd0);
    check("rst_cv", 32'(commit_valid), 32'd0);
    check("rst_we", 32'(completed_we), 32'd0);
    check("rst_num", 32'(completed_dst_num), 32'd0);
    check("rst_ctag", 32'(completed_dst_rrftag), 32'd0);
    q.delete();
    head_p = 0;
    tail_p = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    dp_alloc = 0; dp_dst_en = 0; dp_dst_num = 0; ex_done = 0; ex_rrftag = 0; flush = 0;
    head_p = 0; tail_p = 0;
    async_reset();

    // Two allocations completed out of order.
    step(1, 1, 5, 0, 0, 0);
    step(1, 1, 6, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    idle();
    idle();
    idle();

    // Fill to 64, refused 65th, then full-with-commit refusal and the wrap-around grant.
    for (int i = 0; i < 64; i++) step(1, 1, (i * 7) % 32, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0);
    step(0, 0, 0, 1, q[0].tag, 0);
    step(1, 1, 9, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0);
    drain();

    // No-destination and r0 destinations retire without a write strobe.
    step(1, 0, 7, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, q[0].tag, 0);
    step(0, 0, 0, 1, q[1].tag, 0);
    idle();
    idle();

    // Completion to an unallocated tag is dropped; mid-flight reset clears everything.
    async_reset();
    step(0, 0, 0, 1, 9, 0);
    for (int i = 0; i < 10; i++) step(1, 1, i + 1, 0, 0, 0);
    idle();
    async_reset();
    step(1, 1, 4, 0, 0, 0);
    drain();

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 7; i++) step(1, 1, i + 2, i == 3, q.size() > 0 ? q[0].tag : 0, 0);
    step(1, 1, 1, 1, 0, 1);
    idle();
`endif

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int pa, pd, dtag;
      bit fl;
      case ((cyc / 300) % 4)
        0:       begin pa = 90; pd = 10; end
        1:       begin pa = 50; pd = 60; end
        2:       begin pa = 30; pd = 85; end
        default: begin pa = 70; pd = 40; end
      endcase
      if (q.size() > 0 && $urandom_range(9) < 8) dtag = q[$urandom_range(q.size() - 1)].tag;
      else dtag = int'($urandom_range(63));
`ifdef ROB_FLUSH_EN
      fl = ($urandom_range(99) == 0);
`else
      fl = 1'b0;
`endif
      step($urandom_range(99) < pa, $urandom_range(3) != 0, int'($urandom_range(31)),
           $urandom_range(99) < pd, dtag, fl);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
